mc_main_control: RTL and testbench
==================================

// Module: mc_main_control
// PURPOSE
//  Multi-cycle MIPS main control FSM; initiator of the alu_op interface feeding the ALU control decoder.
//  Decodes opcode from the IR, sequences fetch/decode/execute/memory/writeback, drives datapath selects/enables.
//  Stalls on a memory ready handshake. Flags unsupported opcodes.
// PARAMETERS
//  OP_RTYPE 6'b000000  R-type opcode
//  OP_LW    6'b100011  load word
//  OP_SW    6'b101011  store word
//  OP_BEQ   6'b000100  branch equal
//  OP_J     6'b000010  jump
//  OP_ADDI  6'b001000  add immediate (used only with MC_CTRL_ADDI_EN)
// PORTS
//  clk           in   1  clock, rising edge
//  rst_n         in   1  asynchronous active-low reset
//  opcode        in   6  IR[31:26], valid from DECODE onward
//  mem_ready     in   1  memory done/accepting this cycle
//  pc_write      out  1  unconditional PC load
//  pc_write_cond out  1  PC load if ALU zero
//  pc_source     out  2  00 ALU, 01 ALUOut, 10 jump target
//  i_or_d        out  1  mem addr: 0 PC, 1 ALUOut
//  mem_read      out  1  memory read request
//  mem_write     out  1  memory write request
//  ir_write      out  1  IR load
//  mem_to_reg    out  1  RF write data: 0 ALUOut, 1 MDR
//  reg_dst       out  1  RF write addr: 0 rt, 1 rd
//  reg_write     out  1  RF write enable
//  alu_src_a     out  1  0 PC, 1 reg A
//  alu_src_b     out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  alu_op        out  2  00 add, 01 sub, 10 use funct
//  illegal_op    out  1  one-cycle pulse: unsupported opcode at DECODE
//  state_dbg     out  4  current state encoding
// BEHAVIOUR
//  - 4-bit state reg; Moore outputs decoded combinationally from state (and mem_ready where noted).
//  - rst_n low: state<=FETCH(0) async; all outputs forced 0 (state_dbg=0) while rst_n low.
//  - Unlisted outputs are 0 in each state. States/outputs -> next:
//    0 FETCH: mem_read=1, alu_src_b=01, alu_op=00; ir_write=pc_write=mem_ready -> DECODE if mem_ready else FETCH
//    1 DECODE: alu_src_b=11, alu_op=00 -> lw/sw:2, R:6, beq:8, j:9, addi:10, else FETCH + illegal_op=1
//    2 MEM_ADDR: alu_src_a=1, alu_src_b=10 -> lw:3, sw:5
//    3 MEM_READ: mem_read=1, i_or_d=1 -> 4 if mem_ready else hold
//    4 MEM_WB: reg_write=1, mem_to_reg=1 -> FETCH
//    5 MEM_WRITE: mem_write=1, i_or_d=1 -> FETCH if mem_ready else hold
//    6 EXECUTE: alu_src_a=1, alu_op=10 -> 7
//    7 R_WB: reg_write=1, reg_dst=1 -> FETCH
//    8 BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH
//    9 JUMP: pc_write=1, pc_source=10 -> FETCH
//    10 ADDI_EX: alu_src_a=1, alu_src_b=10 -> 11;  11 ADDI_WB: reg_write=1 -> FETCH
//    codes 12-15 (unreachable): outputs 0 -> FETCH
//  - Instruction cycles (no stalls): R 4, lw 5, sw 4, beq 3, j 3, addi 4; each stall adds 1.
//  - mem_read/mem_write held high through stall; opcode only sampled in DECODE/MEM_ADDR.
//  - mem_ready ignored outside FETCH/MEM_READ/MEM_WRITE.
//  - Reset mid-instruction: aborts immediately, no partial write; restarts at FETCH.
// CONFIGURATION
//  MC_CTRL_ADDI_EN defined: addi decodes to states 10/11 as above.
//  Undefined: addi treated as unsupported (illegal_op pulse, -> FETCH); states 10/11 absent.
// TESTING
//  1 rst_n=0 mid MEM_WRITE -> mem_write=0 at once, state_dbg=0; release, mem_ready=1 -> FETCH outputs.
//  2 opcode=000000, mem_ready=1 -> states 0,1,6,7,0; alu_op=10 in state 6; reg_write&reg_dst in 7.
//  3 lw, mem_ready low 2 cycles in MEM_READ -> holds state 3 with mem_read=1,i_or_d=1; then 4, reg_write&mem_to_reg.
//  4 sw, mem_ready=1 -> 0,1,2,5,0; mem_write=1 only in state 5.
//  5 beq -> state 8: alu_op=01, pc_write_cond=1, pc_source=01; j -> state 9: pc_write=1, pc_source=10.
//  6 opcode=111111 -> illegal_op=1 one cycle in DECODE, next FETCH; addi same unless MC_CTRL_ADDI_EN (then 10,11).

Source files
------------

// File: rtl/mc_main_control.sv
// ============================================================================
// Module   : mc_main_control
// Purpose  : Multi-cycle MIPS main control FSM. It drives the datapath
//            selects and enables, and it originates alu_op for the ALU control
//            decoder.
// Config   : MC_CTRL_ADDI_EN enables addi decoding (states 10/11).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_main_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
`ifdef MC_CTRL_ADDI_EN
    localparam logic [3:0] S_ADDI_EX   = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;
`endif

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [3:0] state_dec;

    // Dispatch target for DECODE. FETCH here means the opcode is unsupported.
    always_comb begin
        state_dec = S_FETCH;
        case (opcode)
            OP_LW, OP_SW: state_dec = S_MEM_ADDR;
            OP_RTYPE:     state_dec = S_EXECUTE;
            OP_BEQ:       state_dec = S_BRANCH;
            OP_J:         state_dec = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
            OP_ADDI:      state_dec = S_ADDI_EX;
`endif
            default:      state_dec = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:    state_d = state_dec;
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_d = S_R_WB;
`ifdef MC_CTRL_ADDI_EN
            S_ADDI_EX:   state_d = S_ADDI_WB;
`endif
            default:     state_d = S_FETCH;
        endcase
    end

    // Outputs are gated by rst_n so that nothing is asserted while reset is held.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal_op    = 1'b0;
        state_dbg     = 4'd0;
        if (rst_n) begin
            state_dbg = state_q;
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal_op = (state_dec == S_FETCH);
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
`ifdef MC_CTRL_ADDI_EN
                S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ADDI_WB: begin
                    reg_write = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_main_control.sv
// ============================================================================
// Module   : tb_mc_main_control
// Purpose  : Self-checking bench for mc_main_control. It uses an
//            instruction-level reference model and random stalls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_main_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;

    mc_main_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .illegal_op    (illegal_op),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle, most significant first:
    // pc_write, pc_write_cond, pc_source[2], i_or_d, mem_read, mem_write,
    // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[2],
    // alu_op[2], illegal_op, state_dbg[4]
    function automatic logic [21:0] observed();
        return {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                alu_op, illegal_op, state_dbg};
    endfunction

    // Expected outputs for a step of the instruction walk.
    function automatic logic [21:0] expected(input int st, input bit rdy, input bit ill);
        logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, asa = 0;
        logic [1:0] ps = 0, asb = 0, aop = 0;
        logic [3:0] sd;
        sd = 4'(st);
        case (st)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            1:  begin asb = 2'b11; end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {pw, pwc, ps, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ill, sd};
    endfunction

    function automatic bit addi_enabled();
`ifdef MC_CTRL_ADDI_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Runs one instruction from FETCH and checks every cycle. The
    // instruction path comes from its opcode class. Stall counts apply to
    // FETCH and to the memory data phase.
    task automatic run_instr(input logic [5:0] op, input int stall_f, input int stall_m,
                             input string name);
        int  st_q[$];
        bit  rdy_q[$];
        bit  ill;
        ill = 1'b0;
        for (int i = 0; i < stall_f; i++) begin st_q.push_back(0); rdy_q.push_back(0); end
        st_q.push_back(0); rdy_q.push_back(1);
        st_q.push_back(1); rdy_q.push_back(1'($urandom));
        case (op)
            6'b000000: begin st_q.push_back(6); st_q.push_back(7); end
            6'b100011: begin
                st_q.push_back(2); rdy_q.push_back(1'($urandom));
                for (int i = 0; i < stall_m; i++) begin st_q.push_back(3); rdy_q.push_back(0); end
                st_q.push_back(3); rdy_q.push_back(1);
                st_q.push_back(4);
            end
            6'b101011: begin
                st_q.push_back(2); rdy_q.push_back(1'($urandom));
                for (int i = 0; i < stall_m; i++) begin st_q.push_back(5); rdy_q.push_back(0); end
                st_q.push_back(5); rdy_q.push_back(1);
            end
            6'b000100: st_q.push_back(8);
            6'b000010: st_q.push_back(9);
            6'b001000: begin
                if (addi_enabled()) begin st_q.push_back(10); st_q.push_back(11); end
                else ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        while (rdy_q.size() < st_q.size()) rdy_q.push_back(1'($urandom));
        for (int k = 0; k < st_q.size(); k++) begin
            opcode    = (st_q[k] == 0) ? 6'($urandom) : op;
            mem_ready = rdy_q[k];
            #1;
            checks++;
            if (observed() !== expected(st_q[k], rdy_q[k], ill && st_q[k] == 1)) begin
                errors++;
                $display("FAIL %s step %0d: got %b expected %b", name, k, observed(),
                         expected(st_q[k], rdy_q[k], ill && st_q[k] == 1));
            end
            @(posedge clk); #1;
        end
        opcode = 6'($urandom);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state_dbg !== 4'd0) begin
            errors++;
            $display("FAIL %s return: state_dbg got %0d expected 0", name, state_dbg);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; opcode = 6'd0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (observed() !== 22'd0) begin
            errors++;
            $display("FAIL reset_hold: got %b expected all zero", observed());
        end
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (observed() !== expected(0, 0, 0)) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", observed(), expected(0, 0, 0));
        end
    endtask

    task automatic test_rtype();     run_instr(6'b000000, 0, 0, "rtype"); endtask
    task automatic test_lw_stall();  run_instr(6'b100011, 0, 2, "lw_stall"); endtask
    task automatic test_sw();        run_instr(6'b101011, 0, 0, "sw"); endtask
    task automatic test_fetch_stall(); run_instr(6'b000000, 3, 0, "fetch_stall"); endtask

    task automatic test_branch_jump();
        run_instr(6'b000100, 0, 0, "beq");
        run_instr(6'b000010, 0, 0, "j");
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 0, 0, "illegal_3f");
        run_instr(6'b001000, 0, 0, "addi");
    endtask

    // Drives an sw into a stalled MEM_WRITE, then aborts it with reset.
    task automatic test_reset_mid();
        mem_ready = 1'b1; opcode = 6'b101011;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b1 || state_dbg !== 4'd5) begin
            errors++;
            $display("FAIL reset_mid_setup: mem_write=%b state=%0d expected 1/5", mem_write, state_dbg);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (observed() !== 22'd0) begin
            errors++;
            $display("FAIL reset_mid_abort: got %b expected all zero", observed());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (observed() !== expected(0, 1, 0)) begin
            errors++;
            $display("FAIL reset_mid_fetch: got %b expected %b", observed(), expected(0, 1, 0));
        end
        @(posedge clk); #1;
        mem_ready = 1'b0; opcode = 6'b000010;
        #1;
        checks++;
        if (state_dbg !== 4'd1) begin
            errors++;
            $display("FAIL reset_mid_decode: state got %0d expected 1", state_dbg);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [5:0] ops [7];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b000000};
        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 7) == 7) op = 6'($urandom);
            else op = ops[$urandom_range(0, 5)];
            run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw();
        test_branch_jump();
        test_illegal();
        test_fetch_stall();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
